prv_trap_arbiter: RTL

- Parametrised trap/interrupt sequencer between the pipeline hazard unit and the machine-mode CSR file.
- Collects NUM_EXC exception flags, NUM_INT level interrupt lines and return requests, and picks one trap by fixed priority.
- Runs a flush handshake with the pipeline, then inserts the redirect PC and pulses cause/epc/tval writes to the CSR file.
- Generalises the fixed-field trap signalling to arbitrary cause counts, adds vectored-mode targets and an explicit drain state machine.

---
 rtl/prv_trap_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/prv_trap_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : prv_trap_arbiter
// Purpose  : Fixed-priority trap/interrupt sequencer. It runs a flush handshake,
//            then redirects the PC and strobes the mcause/mepc/mtval writes.
//            Optional macro TRAP_NMI_EN adds a sticky, edge-triggered NMI.
// Revision : 1.0 - initial release
// ============================================================================
module prv_trap_arbiter #(
    parameter int              NUM_EXC    = 16,
    parameter int              NUM_INT    = 16,
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] NMI_VECTOR = '0
) (
    input  logic               CLK,
    input  logic               nRST,
`ifdef TRAP_NMI_EN
    input  logic               nmi,
`endif
    input  logic [NUM_EXC-1:0] exc_valid,
    input  logic [XLEN-1:0]    exc_epc,
    input  logic [XLEN-1:0]    exc_badaddr,
    input  logic [NUM_INT-1:0] int_lines,
    input  logic [NUM_INT-1:0] int_enable,
    input  logic               global_ie,
    input  logic               ret,
    input  logic               pipe_clear,
    input  logic [XLEN-1:0]    mtvec,
    input  logic [XLEN-1:0]    mepc_r,
    output logic               intr,
    output logic               insert_pc,
    output logic [XLEN-1:0]    priv_pc,
    output logic               cause_we,
    output logic [XLEN-1:0]    trap_cause,
    output logic [XLEN-1:0]    trap_epc,
    output logic [XLEN-1:0]    trap_tval,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_INSERT = 2'd2
    } state_t;

    localparam logic [1:0] c_kind_exc = 2'd0;
    localparam logic [1:0] c_kind_int = 2'd1;
    localparam logic [1:0] c_kind_ret = 2'd2;
    localparam logic [1:0] c_kind_nmi = 2'd3;

    state_t            r_state;
    logic [1:0]        r_kind;
    logic [XLEN-1:0]   r_idx;

    logic [NUM_INT-1:0] w_pend;
    logic               w_exc_hit;
    logic               w_int_hit;
    logic [XLEN-1:0]    w_exc_idx;
    logic [XLEN-1:0]    w_int_idx;
    logic [XLEN-1:0]    w_base;
    logic [XLEN-1:0]    w_target;
    logic               w_nmi_take;

    assign w_pend = int_lines & int_enable & {NUM_INT{global_ie}};
    assign w_base = {mtvec[XLEN-1:2], 2'b00};

    // Descending scan leaves the lowest exception; ascending leaves the highest interrupt.
    always_comb begin
        w_exc_hit = 1'b0;
        w_exc_idx = '0;
        for (int i = NUM_EXC - 1; i >= 0; i--) begin
            if (exc_valid[i]) begin
                w_exc_hit = 1'b1;
                w_exc_idx = XLEN'(i);
            end
        end
        w_int_hit = 1'b0;
        w_int_idx = '0;
        for (int j = 0; j < NUM_INT; j++) begin
            if (w_pend[j]) begin
                w_int_hit = 1'b1;
                w_int_idx = XLEN'(j);
            end
        end
    end

    always_comb begin
        w_target = w_base;
        case (r_kind)
            c_kind_int: w_target = (mtvec[1:0] == 2'b01) ? w_base + (r_idx << 2) : w_base;
            c_kind_ret: w_target = mepc_r;
`ifdef TRAP_NMI_EN
            c_kind_nmi: w_target = NMI_VECTOR;
`endif
            default:    w_target = w_base;
        endcase
    end

`ifdef TRAP_NMI_EN
    logic r_nmi_q;
    logic r_nmi_pend;

    // A new edge wins over the clear so an NMI landing during INSERT is never lost.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_nmi_q    <= 1'b0;
            r_nmi_pend <= 1'b0;
        end else begin
            r_nmi_q <= nmi;
            if (nmi && !r_nmi_q)
                r_nmi_pend <= 1'b1;
            else if (r_state == ST_INSERT && r_kind == c_kind_nmi)
                r_nmi_pend <= 1'b0;
        end
    end
    assign w_nmi_take = r_nmi_pend;
`else
    assign w_nmi_take = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= ST_IDLE;
            r_kind     <= c_kind_exc;
            r_idx      <= '0;
            intr       <= 1'b0;
            insert_pc  <= 1'b0;
            priv_pc    <= '0;
            cause_we   <= 1'b0;
            trap_cause <= '0;
            trap_epc   <= '0;
            trap_tval  <= '0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    insert_pc <= 1'b0;
                    cause_we  <= 1'b0;
                    if (w_nmi_take || w_exc_hit || w_int_hit || ret) begin
                        r_state  <= ST_DRAIN;
                        intr     <= 1'b1;
                        busy     <= 1'b1;
                        trap_epc <= exc_epc;
                        if (w_nmi_take) begin
                            r_kind     <= c_kind_nmi;
                            r_idx      <= '0;
                            trap_cause <= {1'b1, {(XLEN-1){1'b0}}};
                            trap_tval  <= '0;
                        end else if (w_exc_hit) begin
                            r_kind     <= c_kind_exc;
                            r_idx      <= w_exc_idx;
                            trap_cause <= w_exc_idx;
                            trap_tval  <= exc_badaddr;
                        end else if (w_int_hit) begin
                            r_kind     <= c_kind_int;
                            r_idx      <= w_int_idx;
                            trap_cause <= w_int_idx | {1'b1, {(XLEN-1){1'b0}}};
                            trap_tval  <= '0;
                        end else begin
                            r_kind     <= c_kind_ret;
                            r_idx      <= '0;
                            trap_cause <= '0;
                            trap_tval  <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pipe_clear) begin
                        r_state   <= ST_INSERT;
                        intr      <= 1'b0;
                        insert_pc <= 1'b1;
                        priv_pc   <= w_target;
                        cause_we  <= (r_kind != c_kind_ret);
                    end
                end
                ST_INSERT: begin
                    r_state   <= ST_IDLE;
                    insert_pc <= 1'b0;
                    cause_we  <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    intr    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
